stencil_window_gen: RTL and testbench
=====================================

STENCIL_WINDOW_GEN -- requirements
Module: stencil_window_gen

Interface
REQ-001 SHALL have parameter PIX_W, 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, 488, pixels per row (>= K).
REQ-003 SHALL have parameter IMG_H, 648, rows per frame (>= K).
REQ-004 SHALL have parameter K, 9, window edge; odd, 3..15.
REQ-005 SHALL have port clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port step  input  1  clock enable; all state holds when 0.
REQ-008 SHALL have port arg_1_TDATA  input  PIX_W  input pixel, raster order.
REQ-009 SHALL have port arg_1_TVALID  input  1  input pixel valid.
REQ-010 SHALL have port arg_1_TREADY  output  1  input accept.
REQ-011 SHALL have port arg_0_TDATA  output  K*K*PIX_W  window; element (r,c) at bits [(r*K+c)*PIX_W +: PIX_W], r=0 oldest row, c=0 oldest column.
REQ-012 SHALL have port arg_0_TVALID  output  1  window valid.
REQ-013 SHALL have port arg_0_TREADY  input  1  downstream accept.
REQ-014 SHALL have port arg_0_TLAST  output  1  last window of frame.
REQ-015 SHALL have ports RAM_x output clog2(IMG_W) and RAM_y output clog2(IMG_H): column/row of next pixel to accept.

Function
REQ-016 SHALL accept a pixel in a cycle where step=1, arg_1_TVALID=1, arg_1_TREADY=1 ("accept").
REQ-017 SHALL drive arg_1_TREADY = !arg_0_TVALID | arg_0_TREADY (combinational).
REQ-018 SHALL hold K-1 line buffers of IMG_W x PIX_W, read asynchronously at RAM_x; contents not reset.
REQ-019 On accept SHALL form new column {lb[K-2][x],...,lb[0][x],pixel} (oldest first), write lb[i][x]<=lb[i-1][x], lb[0][x]<=pixel.
REQ-020 On accept SHALL shift window one column toward c=0 and load new column at c=K-1.
REQ-021 On accept SHALL advance RAM_x; at IMG_W-1 wrap to 0 and increment RAM_y; at (IMG_W-1, IMG_H-1) wrap both to 0.
REQ-022 On accept with x>=K-1 and y>=K-1 SHALL set arg_0_TVALID=1 next cycle (latency 1) with updated window.
REQ-023 SHALL set arg_0_TLAST=1 with the window produced by accept at (IMG_W-1, IMG_H-1), else 0.
REQ-024 SHALL clear arg_0_TVALID when step=1, arg_0_TREADY=1 and no qualifying accept; accept and drain in same cycle keep TVALID=1 with new data.
REQ-025 While arg_0_TVALID=1 and arg_0_TREADY=0, arg_0_TDATA/TLAST SHALL be stable.
REQ-026 SHALL emit exactly (IMG_W-K+1)*(IMG_H-K+1) windows per frame; no border padding.
REQ-027 SHALL carry line-buffer contents across frame boundaries; windows of new frame gated by REQ-022 only.
REQ-028 When step=0 SHALL change no register or memory, regardless of handshake inputs.

Reset
REQ-029 On rst=1 at clk edge (overrides step) SHALL set RAM_x=0, RAM_y=0, arg_0_TVALID=0, arg_0_TLAST=0, window=0.
REQ-030 Reset mid-frame SHALL discard partial frame; next accepted pixel is (0,0).

Structure
REQ-031 SHALL place window index/bit-offset helper and clog2 constants in shared package gb_pkg.
REQ-032 SHALL use one sub-module, line_buf (single-port IMG_W x PIX_W, async read, sync write), instantiated K-1 times.

Verification (K=3, IMG_W=5, IMG_H=4, PIX_W=8, pixel value = 5y+x)
REQ-033 Stream one frame, TREADY=1 -> first window after pixel 12: rows {0,1,2},{5,6,7},{10,11,12}; 6 windows total.
REQ-034 Same frame -> TLAST=1 only on window ending 19 (rows {9,..},{14},{19} i.e. {7,8,9},{12,13,14},{17,18,19}).
REQ-035 arg_0_TREADY=0 for 5 cycles after first window -> TDATA stable, arg_1_TREADY=0, RAM_x frozen at 3.
REQ-036 step=0 for 4 cycles mid-row with TVALID=1 -> RAM_x, RAM_y, outputs unchanged.
REQ-037 rst at pixel 8 then restream full frame -> TVALID=0, RAM_x=RAM_y=0 next cycle; 6 correct windows follow.
REQ-038 Two back-to-back frames -> 12 windows, second frame windows identical to first, two TLAST pulses.

Source files
------------

// File: rtl/gb_pkg.sv
// gb_pkg: shared address-width helper, window offset helper and default widths
package gb_pkg;
  function automatic int aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int win_off(input int r, input int c, input int k, input int pw);
    return (r * k + c) * pw;
  endfunction
  localparam int DEF_XW = aw(488);
  localparam int DEF_YW = aw(648);
endpackage

// File: rtl/line_buf.sv
// line_buf: single-port line memory, async read and sync write at one address
// Ports: clk; we_i write enable; addr_i column; din_i write data; dout_o read data.
module line_buf
  import gb_pkg::*;
#(
  parameter int DEPTH = 488,
  parameter int W     = 8,
  parameter int AW    = DEF_XW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[addr_i] <= din_i;
  assign dout_o = mem_q[addr_i];
endmodule

// File: rtl/stencil_window_gen.sv
// stencil_window_gen: KxK sliding window over a raster pixel stream
// Ports: clk/rst (sync active-high); step clock enable; arg_1_* pixel input stream;
// arg_0_* window output stream with TLAST on the frame's final window;
// RAM_x/RAM_y column/row of the next pixel to accept.
module stencil_window_gen
  import gb_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 488,
  parameter int IMG_H = 648,
  parameter int K     = 9,
  localparam int XW   = aw(IMG_W),
  localparam int YW   = aw(IMG_H),
  localparam int WW   = K * K * PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [PIX_W-1:0] arg_1_TDATA,
  input  logic             arg_1_TVALID,
  output logic             arg_1_TREADY,
  output logic [WW-1:0]    arg_0_TDATA,
  output logic             arg_0_TVALID,
  input  logic             arg_0_TREADY,
  output logic             arg_0_TLAST,
  output logic [XW-1:0]    RAM_x,
  output logic [YW-1:0]    RAM_y
);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic vld_q, vld_d, last_q, last_d;
  logic [WW-1:0] win_q, win_d;
  logic acc, x_end, at_end, qual;
  logic [PIX_W-1:0] lb_out [K-1];
  logic [PIX_W-1:0] col [K];
  assign arg_1_TREADY = !vld_q | arg_0_TREADY;
  assign acc    = step & arg_1_TVALID & arg_1_TREADY;
  assign x_end  = x_q == XW'(IMG_W - 1);
  assign at_end = x_end & (y_q == YW'(IMG_H - 1));
  assign qual   = (x_q >= XW'(K - 1)) & (y_q >= YW'(K - 1));
  // col[0] is the oldest row; the buffers form a vertical shift chain per column
  assign col[K-1] = arg_1_TDATA;
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign col[r] = lb_out[K-2-r];
  end
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(XW)) u_lb (
      .clk   (clk),
      .we_i  (acc & !rst),
      .addr_i(x_q),
      .din_i (col[K-1-i]),
      .dout_o(lb_out[i])
    );
  end
  // shifting the flat vector by one pixel moves every (r,c+1) to (r,c);
  // the c=K-1 slots then receive the new column
  always_comb begin
    x_d    = !acc ? x_q : x_end ? '0 : x_q + 1'b1;
    y_d    = (!acc || !x_end) ? y_q : at_end ? '0 : y_q + 1'b1;
    vld_d  = acc ? qual : vld_q & ~arg_0_TREADY;
    last_d = acc ? qual & at_end : last_q & ~arg_0_TREADY;
    win_d  = acc ? win_q >> PIX_W : win_q;
    if (acc) for (int r = 0; r < K; r++) win_d[win_off(r, K - 1, K, PIX_W) +: PIX_W] = col[r];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      win_q  <= '0;
    end else if (step) begin
      x_q    <= x_d;
      y_q    <= y_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      win_q  <= win_d;
    end
  end
  assign arg_0_TDATA  = win_q;
  assign arg_0_TVALID = vld_q;
  assign arg_0_TLAST  = last_q;
  assign RAM_x        = x_q;
  assign RAM_y        = y_q;
endmodule

// File: tb/tb_stencil_window_gen.sv
// tb_stencil_window_gen: directed vector bench for a 5x4 frame with a 3x3 window
module tb_stencil_window_gen;
  localparam int IW = 5, IH = 4, KK = 3, PW = 8;
  logic clk = 1'b0, rst, step, in_v, in_r, out_v, out_r, out_l;
  logic [7:0] in_d;
  logic [71:0] out_d;
  logic [2:0] rx;
  logic [1:0] ry;
  always #5 clk = ~clk;

  stencil_window_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .K(KK)) dut (
    .clk(clk), .rst(rst), .step(step),
    .arg_1_TDATA(in_d), .arg_1_TVALID(in_v), .arg_1_TREADY(in_r),
    .arg_0_TDATA(out_d), .arg_0_TVALID(out_v), .arg_0_TREADY(out_r), .arg_0_TLAST(out_l),
    .RAM_x(rx), .RAM_y(ry)
  );

  typedef struct {
    logic [7:0]  pix;
    logic        v;
    logic        l;
    logic [71:0] w;
  } vec_t;
  vec_t tbl [20];
  int tests = 0, fails = 0, nwin = 0, nlast = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] win_of(input int x, input int y);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'(5 * (y - 2 + r) + (x - 2 + c));
    return w;
  endfunction

  task automatic run_frame(input int n, input int stall_at, input int off_at);
    for (int i = 0; i < n; i++) begin
      in_v = 1'b1;
      in_d = tbl[i].pix;
      if (i == stall_at) begin
        out_r = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", out_d, tbl[i-1].w);
          chk("stall_in_ready", 72'(in_r), 72'd0);
          chk("stall_x", 72'(rx), 72'(i % 5));
          chk("stall_valid", 72'(out_v), 72'd1);
        end
        out_r = 1'b1;
      end
      if (i == off_at) begin
        step = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("hold_x", 72'(rx), 72'(i % 5));
          chk("hold_y", 72'(ry), 72'(i / 5));
          chk("hold_valid", 72'(out_v), 72'd1);
          chk("hold_data", out_d, tbl[i-1].w);
          chk("hold_last", 72'(out_l), 72'(tbl[i-1].l));
        end
        step = 1'b1;
      end
      @(negedge clk);
      chk("valid", 72'(out_v), 72'(tbl[i].v));
      nwin += int'(out_v);
      nlast += int'(out_v & out_l);
      if (tbl[i].v) begin
        chk("window", out_d, tbl[i].w);
        chk("last", 72'(out_l), 72'(tbl[i].l));
      end
      if (i == 12) chk("first_window", out_d, 72'h0c0b0a_070605_020100);
      if (i == 19) chk("final_window", out_d, 72'h131211_0e0d0c_090807);
    end
    in_v = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].pix = 8'(i);
      tbl[i].v   = (i % 5 >= 2) && (i / 5 >= 2);
      tbl[i].l   = (i == 19);
      tbl[i].w   = tbl[i].v ? win_of(i % 5, i / 5) : '0;
    end
    rst = 1'b1; step = 1'b1; in_v = 1'b0; in_d = '0; out_r = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 72'(out_v), 72'd0);
    chk("rst_last", 72'(out_l), 72'd0);
    chk("rst_x", 72'(rx), 72'd0);
    chk("rst_y", 72'(ry), 72'd0);
    chk("rst_data", out_d, 72'd0);
    rst = 1'b0;
    nwin = 0; nlast = 0;
    run_frame(20, -1, -1);
    run_frame(20, -1, -1);
    chk("two_frame_windows", 72'(nwin), 72'd12);
    chk("two_frame_tlast", 72'(nlast), 72'd2);
    nwin = 0; nlast = 0;
    run_frame(20, 13, 14);
    chk("stall_frame_windows", 72'(nwin), 72'd6);
    run_frame(8, -1, -1);
    in_v = 1'b1; in_d = 8'd8; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_v = 1'b0;
    chk("midrst_valid", 72'(out_v), 72'd0);
    chk("midrst_x", 72'(rx), 72'd0);
    chk("midrst_y", 72'(ry), 72'd0);
    nwin = 0; nlast = 0;
    run_frame(20, -1, -1);
    chk("post_rst_windows", 72'(nwin), 72'd6);
    chk("post_rst_tlast", 72'(nlast), 72'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
